// File: rtl/reg_a_load_ctrl.sv
// Register-A load sequencer: selects the A source, strobes memory reads for MEM_LATENCY cycles,
// pulses the A write enable and reports completion. Optional REG_A_LOAD_STATS_EN adds load_count_o.
module reg_a_load_ctrl #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic [1:0]  req_op_i,
    output logic        req_ready_o,
    input  logic        flush_i,
    output logic [1:0]  mux_a_sel_o,
    output logic        mem_read_o,
    output logic        a_write_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
`ifdef REG_A_LOAD_STATS_EN
    ,
    output logic [15:0] load_count_o
`endif
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // A flush in the same cycle drops the request entirely.
                if (req_valid_i && !flush_i) begin
                    op_d = req_op_i;
                    if (req_op_i == OP_MEM) begin
                        state_d = MEM_WAIT;
                        cnt_d   = CW'(MEM_LATENCY - 1);
                    end else if (req_op_i == OP_ILL) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == '0) state_d = WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WRITE: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign mem_read_o  = (state_q == MEM_WAIT);
    assign a_write_o   = (state_q == WRITE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign mux_a_sel_o = op_q;

`ifdef REG_A_LOAD_STATS_EN
    logic [15:0] load_count_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i)               load_count_q <= '0;
        else if (state_q == WRITE)  load_count_q <= load_count_q + 16'd1;
    end

    assign load_count_o = load_count_q;
`endif

endmodule

// File: tb/tb_reg_a_load_ctrl.sv
// Scoreboard bench for reg_a_load_ctrl: stimulus queues expected completions, a negedge monitor
// measures accept-to-done latency, write/read strobe counts and the select seen at the write.
module tb_reg_a_load_ctrl;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_op;
    logic        req_ready;
    logic        flush;
    logic [1:0]  mux_a_sel;
    logic        mem_read;
    logic        a_write;
    logic        busy;
    logic        done;
    logic        err;
`ifdef REG_A_LOAD_STATS_EN
    logic [15:0] load_count;
`endif

    reg_a_load_ctrl #(.MEM_LATENCY(L)) dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .req_valid_i (req_valid),
        .req_op_i    (req_op),
        .req_ready_o (req_ready),
        .flush_i     (flush),
        .mux_a_sel_o (mux_a_sel),
        .mem_read_o  (mem_read),
        .a_write_o   (a_write),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
`ifdef REG_A_LOAD_STATS_EN
        ,
        .load_count_o(load_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        int         err;
        int         aw;
        int         mr;
        logic [1:0] sel;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_writes = 0;
    int   aw_total = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: per-transaction counters restart at every observed accept.
    int         acc_cyc = 0, aw = 0, mr = 0;
    logic [1:0] sel_w = 2'b00;
    bit         chk_ready = 0;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_total  = 0;
            chk_ready = 0;
        end else begin
            if (chk_ready) begin
                check("ready_after_done", int'(req_ready), 1);
                chk_ready = 0;
            end
            if (req_valid && req_ready && !flush) begin
                acc_cyc = cyc; aw = 0; mr = 0;
            end
            if (a_write) begin
                aw++; aw_total++; sel_w = mux_a_sel;
            end
            if (mem_read) mr++;
            if (err && !done) check("err_without_done", int'(err), 0);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc - acc_cyc, e.lat);
                    check("err", int'(err), e.err);
                    check("a_write_count", aw, e.aw);
                    check("mem_read_count", mr, e.mr);
                    if (e.err == 0) check("sel_at_write", int'(sel_w), int'(e.sel));
                    check("busy_in_done", int'(busy), 1);
                    chk_ready = 1;
                end
            end
        end
    end

    // Leaves req_valid high on return so callers can chain requests back to back.
    task automatic issue(input logic [1:0] op, input bit push);
        exp_t x;
        bit   accepted = 0;
        req_valid = 1'b1;
        req_op    = op;
        if (push) begin
            x.sel = op;
            x.mr  = 0;
            x.aw  = 1;
            x.err = 0;
            case (op)
                2'b00:   begin x.lat = 2 + L; x.mr = L; end
                2'b11:   begin x.lat = 1; x.aw = 0; x.err = 1; end
                default: x.lat = 2;
            endcase
            q.push_back(x);
            if (op != 2'b11) exp_writes++;
        end
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready && !flush) begin
                @(posedge clk); #1;
                accepted = 1;
            end
        end
        check("accept", int'(accepted), 1);
    endtask

    task automatic idle_wait();
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(mux_a_sel), 0);
        check("rst_outs", int'({mem_read, a_write, done, err}), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while in WRITE with op 10: select must return to 00.
        issue(2'b10, 0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_sel", int'(mux_a_sel), 0);
        check("midrst_ready", int'(req_ready), 1);
        check("midrst_write", int'(a_write), 0);
        exp_writes = 0;
        @(posedge clk); #1;

        issue(2'b01, 1); idle_wait();
        check("sel_held_01", int'(mux_a_sel), 1);
        issue(2'b10, 1); idle_wait();
        issue(2'b00, 1); idle_wait();
        issue(2'b11, 1); idle_wait();

        // Flush during the first MEM_WAIT cycle.
        issue(2'b00, 0);
        req_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_ready", int'(req_ready), 1);
        check("flush_busy", int'(busy), 0);
        check("flush_memrd", int'(mem_read), 0);
        @(posedge clk); #1;
        // Flush coincident with a request in IDLE drops it.
        req_valid = 1'b1; req_op = 2'b01; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_drop_busy", int'(busy), 0);
        @(posedge clk); #1;
        issue(2'b01, 1); idle_wait();

        // req_valid held high across two back-to-back requests.
        issue(2'b01, 1);
        issue(2'b10, 1);
        idle_wait();

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("write_total", aw_total, exp_writes);
`ifdef REG_A_LOAD_STATS_EN
        check("load_count", int'(load_count), exp_writes);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
